// File: rtl/life_manager.sv
// ============================================================================
// life_manager
// ----------------------------------------------------------------------------
// Owns the player's life count and drives the heart HUD. Runs on the frame
// clock, so one cycle is one video frame. Hit / heal / restart are one-frame
// pulses from game logic. All status outputs are registered; the heart tile
// positions are constants.
//
// Optional feature macro: LIFE_HEAL_EN
//   defined   -> heal port present, a heal adds one life (saturating at 3)
//   undefined -> no heal port, life only decrements or resets to 3
//
// Parameters:
//   INV_FRAMES  invincibility length in frames after a hit (2..1023)
//   BLINK_BIT   invincibility counter bit driving blink
//   HEART_ROW   tile row of all hearts
//   HEART_COL0  tile column of heart 0 (heart i at HEART_COL0+i)
//
// Ports:
//   frame_clk     in   frame clock
//   RESET_n       in   asynchronous reset, active low
//   hit           in   damage pulse
//   heal          in   heal pulse (LIFE_HEAL_EN only)
//   restart       in   new-game pulse, overrides hit/heal
//   life          out  lives remaining, 0..3
//   invincible    out  high while in INVINC
//   blink         out  HUD blink phase
//   game_over     out  high while in DEAD
//   heart_row[3]  out  tile row per heart
//   heart_col[3]  out  tile column per heart
// ============================================================================
module life_manager #(
    parameter int INV_FRAMES = 60,
    parameter int BLINK_BIT  = 2,
    parameter int HEART_ROW  = 1,
    parameter int HEART_COL0 = 1
) (
    input  logic       frame_clk,
    input  logic       RESET_n,
    input  logic       hit,
`ifdef LIFE_HEAL_EN
    input  logic       heal,
`endif
    input  logic       restart,
    output logic [1:0] life,
    output logic       invincible,
    output logic       blink,
    output logic       game_over,
    output logic [9:0] heart_row [3],
    output logic [9:0] heart_col [3]
);

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVINC = 2'd1,
        DEAD   = 2'd2
    } state_t;

    localparam logic [9:0] INV_TC = 10'(INV_FRAMES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [9:0] r_inv_cnt;
    logic [9:0] w_cnt_nxt;
    logic [1:0] w_life_nxt;
    logic       w_heal;
    logic       w_inv_last;

`ifdef LIFE_HEAL_EN
    assign w_heal = heal;
`else
    assign w_heal = 1'b0;
`endif

    // Last INVINC frame: the edge that returns to ALIVE also accepts a hit,
    // so this frame evaluates its inputs exactly as ALIVE would.
    assign w_inv_last = (r_state == INVINC) && (r_inv_cnt >= INV_TC);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_inv_cnt;
        w_life_nxt  = life;
        if (restart) begin
            w_state_nxt = ALIVE;
            w_cnt_nxt   = 10'd0;
            w_life_nxt  = 2'd3;
        end else begin
            case (r_state)
                ALIVE, INVINC: begin
                    if (r_state == ALIVE || w_inv_last) begin
                        w_state_nxt = ALIVE;
                        w_cnt_nxt   = 10'd0;
                        // Hit has priority over heal outside invincibility.
                        if (hit) begin
                            if (life >= 2'd2) begin
                                w_life_nxt  = life - 2'd1;
                                w_state_nxt = INVINC;
                            end else begin
                                w_life_nxt  = 2'd0;
                                w_state_nxt = DEAD;
                            end
                        end else if (w_heal && life != 2'd3) begin
                            w_life_nxt = life + 2'd1;
                        end
                    end else begin
                        // Hits are dropped while invincible; heal still counts.
                        w_cnt_nxt = r_inv_cnt + 10'd1;
                        if (w_heal && life != 2'd3) begin
                            w_life_nxt = life + 2'd1;
                        end
                    end
                end
                DEAD: begin
                    w_life_nxt = 2'd0;
                end
                default: begin
                    w_state_nxt = ALIVE;
                    w_cnt_nxt   = 10'd0;
                    w_life_nxt  = 2'd3;
                end
            endcase
        end
    end

    // Flags are derived from next-state values so they line up with life.
    always_ff @(posedge frame_clk or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state    <= ALIVE;
            r_inv_cnt  <= 10'd0;
            life       <= 2'd3;
            invincible <= 1'b0;
            blink      <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inv_cnt  <= w_cnt_nxt;
            life       <= w_life_nxt;
            invincible <= (w_state_nxt == INVINC);
            blink      <= (w_state_nxt == INVINC) && w_cnt_nxt[BLINK_BIT];
            game_over  <= (w_state_nxt == DEAD);
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_heart
        assign heart_row[gi] = 10'(HEART_ROW);
        assign heart_col[gi] = 10'(HEART_COL0 + gi);
    end

endmodule
